// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults, address width and FSM encoding for the memory responder
package mem_pkg;

    localparam int DEPTH_DEF       = 512;
    localparam int ADDR_W          = $clog2(DEPTH_DEF);
    localparam int WAIT_STATES_DEF = 2;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word memory, synchronous write, registered read, no reset
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write stores the word; read only updates rdata, so it holds between reads
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder; MEM_BOUNDS_CHECK_EN enables out-of-range flagging
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] MAR_D,
    input  logic [31:0] MDR_D,
    output logic [31:0] mdatain,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic             op_wr_q;
    logic             rd_vld_q;
    logic             oob_q;
    logic             accept;
    logic             access;
    logic [31:0]      arr_rdata;

    assign accept = (state_q == IDLE) && (read || write);
    assign access = (state_q == WAIT) && (cnt_q == '0);

    // State register; reset drops any in-flight request before it reaches memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (read || write) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches and wait counter; rd_vld_q marks that mdatain shows array data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_wr_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= CNT_W'(WAIT_STATES);
                addr_q  <= MAR_D[AW-1:0];
                wdata_q <= MDR_D;
                op_wr_q <= write;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access && !op_wr_q) begin
                rd_vld_q <= !oob_q;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // Capture whether the accepted address lies beyond the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_q <= 1'b0;
        end else if (accept) begin
            oob_q <= ((MAR_D >> AW) != 32'd0);
        end
    end

    assign mem_err = (state_q == DONE) && oob_q;
`else
    logic unused_addr_hi;

    assign oob_q          = 1'b0;
    assign unused_addr_hi = ^MAR_D[31:AW];
    assign mem_err        = 1'b0;
`endif

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (access && !oob_q),
        .we    (op_wr_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mdatain   = rd_vld_q ? arr_rdata : 32'd0;
    assign mem_ready = (state_q == DONE);
    assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with 2 and 0 wait states
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] mar  [2];
    logic [31:0] mdr  [2];
    logic [31:0] mdat [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_responder #(.DEPTH(512), .WAIT_STATES(2)) dut0 (
        .clk(clk), .reset(rst_n), .read(rd[0]), .write(wr[0]), .MAR_D(mar[0]), .MDR_D(mdr[0]),
        .mdatain(mdat[0]), .mem_ready(rdy[0]), .mem_busy(busy[0]), .mem_err(err[0])
    );

    mem_responder #(.DEPTH(512), .WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(rst_n), .read(rd[1]), .write(wr[1]), .MAR_D(mar[1]), .MDR_D(mdr[1]),
        .mdatain(mdat[1]), .mem_ready(rdy[1]), .mem_busy(busy[1]), .mem_err(err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(int i, int c, logic [31:0] d, logic e);
        exp_t x;
        x.cyc  = c;
        x.data = d;
        x.err  = e;
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        while (busy[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL idle_timeout%0d: busy still 1 after %0d cycles, required 0", i, n);
        end
    endtask

    task automatic do_req(int i, logic r, logic w, logic [31:0] a, logic [31:0] d,
                          logic [31:0] ed, logic ee);
        @(negedge clk);
        rd[i] = r; wr[i] = w; mar[i] = a; mdr[i] = d;
        push(i, cyc + 1 + ws_of(i) + 1, ed, ee);
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        chk($sformatf("busy_after_accept%0d", i), 32'(busy[i]), 32'd1);
        wait_idle(i);
    endtask

    task automatic chk_zero(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_mdatain%0d", tag, i), mdat[i], 32'd0);
            chk($sformatf("%s_ready%0d", tag, i), 32'(rdy[i]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
            chk($sformatf("%s_err%0d", tag, i), 32'(err[i]), 32'd0);
        end
    endtask

    // Monitor: every ready pulse pops the oldest expectation for that instance
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (rdy[i]) begin
                    have = 1'b0;
                    if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready%0d: ready=1 at cycle %0d, required no completion", i, cyc);
                    end else begin
                        chk($sformatf("latency%0d", i), 32'(cyc), 32'(e.cyc));
                        chk($sformatf("mdatain%0d", i), mdat[i], e.data);
                        chk($sformatf("mem_err%0d", i), 32'(err[i]), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        int k;
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; mar[i] = 32'd0; mdr[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Two wait states: write/read, read+write priority, ignored mid-wait traffic
        do_req(0, 1'b0, 1'b1, 32'd85, 32'h0000_0055, 32'd0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'd85, 32'd0, 32'h0000_0055, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'd5, 32'hA5A5_0005, 32'h0000_0055, 1'b0);
        do_req(0, 1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF, 32'h0000_0055, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'd10, 32'd0, 32'hDEAD_BEEF, 1'b0);

        @(negedge clk);
        rd[0] = 1'b1; mar[0] = 32'd85;
        push(0, cyc + 4, 32'h0000_0055, 1'b0);
        @(negedge clk);
        rd[0] = 1'b0; mar[0] = 32'd10;
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b1; mdr[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b0;
        wait_idle(0);
        do_req(0, 1'b1, 1'b0, 32'd10, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Reset in the middle of a write must abort it
        @(negedge clk);
        wr[0] = 1'b1; mar[0] = 32'd5; mdr[0] = 32'hFFFF_0000;
        @(negedge clk);
        wr[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1'b1, 1'b0, 32'd5, 32'd0, 32'hA5A5_0005, 1'b0);

        // Address above the array: flagged with bounds check, aliased without
        do_req(0, 1'b0, 1'b1, 32'd0, 32'h0BAD_0000, 32'hA5A5_0005, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 32'hA5A5_0005, BC);
        do_req(0, 1'b1, 1'b0, 32'd0, 32'd0, BC ? 32'h0BAD_0000 : 32'h0000_1234, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'd0, BC ? 32'd0 : 32'h0000_1234, BC);

        // Zero wait states: single-edge latency and re-accept of a held read
        do_req(1, 1'b0, 1'b1, 32'd3, 32'h0000_0033, 32'd0, 1'b0);
        @(negedge clk);
        k = cyc;
        rd[1] = 1'b1; mar[1] = 32'd3;
        push(1, k + 2, 32'h0000_0033, 1'b0);
        push(1, k + 5, 32'h0000_0033, 1'b0);
        repeat (4) @(negedge clk);
        rd[1] = 1'b0;
        wait_idle(1);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("queue0_empty", 32'(q0.size()), 32'd0);
        chk("queue1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
